// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared scan state encodings and default timing constants
package seg_scan_pkg;

  // Scanner phase: a digit is either lit (SHOW) or in its blanking gap (GAP)
  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  // Defaults shared with the decoder top level
  localparam int DEFAULT_DIGITS       = 4;
  localparam int DEFAULT_PRESCALE     = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 16;

  // Counter width able to hold 0..n-1, at least one bit
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_lz_mask.sv
// rtl/seg_scan_lz_mask.sv - leading-zero suppress vector for the digit scanner
module seg_scan_lz_mask #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] active,
  input  logic                lz_en,
  output logic [DIGITS-1:0]   suppress
);

  logic zero_run;

  // Walk from the most significant digit down while every nibble seen is zero
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (active[4*i +: 4] == 4'h0);
      suppress[i] = lz_en & zero_run;
    end
    // The rightmost digit always shows, so a zero value still reads "0"
    suppress[0] = 1'b0;
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed hex digit scanner with blanking and tear-free updates
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = DEFAULT_DIGITS,
  parameter int PRESCALE     = DEFAULT_PRESCALE,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                lz_en,
  output logic [3:0]          nibble_out,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_done
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = count_width(CNT_MAX);
  localparam int IDX_W   = count_width(DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  scan_state_t         state;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;
  logic [DIGITS-1:0]   suppress;

  seg_scan_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .active   (active),
    .lz_en    (lz_en),
    .suppress (suppress)
  );

  // Scan sequencer: SHOW/GAP timing, digit index, frame wrap and shadow hand-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SHOW;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHOW;
            if (idx == IDX_LAST) begin
              idx        <= '0;
              frame_done <= 1'b1;
              // Only the frame boundary may change what is displayed
              if (pending) begin
                active  <= shadow;
                pending <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SHOW;
          cnt   <= '0;
        end
      endcase
      // Placed last so a load on the wrap edge keeps pending set for the next frame
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  // Output decode: nibble of the current digit and its active-low enable
  always_comb begin
    nibble_out = 4'h0;
    digit_sel  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble_out = active[4*i +: 4];
        if (state == SHOW && !suppress[i]) begin
          digit_sel[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized and directed checks of seg_scan against a frame-level model
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int PRE    = 4;
  localparam int BLK    = 2;
  localparam int DPER   = PRE + BLK;
  localparam int FPER   = DIGITS * DPER;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        lz_en;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int total;
  int bad;

  int          t;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pend;

  seg_scan #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRE),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .nibble_out (nibble_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    t        = 0;
    m_active = 16'h0;
    m_shadow = 16'h0;
    m_pend   = 1'b0;
  endtask

  task automatic check(input string tag);
    int          p;
    int          d;
    bit          show;
    bit          supp;
    logic [3:0]  exp_nib;
    logic [3:0]  exp_sel;
    logic        exp_fd;
    logic [15:0] upper;
    p       = t % FPER;
    d       = p / DPER;
    show    = (p % DPER) < PRE;
    exp_nib = m_active[4*d +: 4];
    upper   = m_active >> (4 * d);
    supp    = lz_en && (d > 0) && (upper == 16'h0);
    exp_sel = (show && !supp) ? ~(4'b0001 << d) : 4'hF;
    exp_fd  = (t > 0) && (p == 0);
    total++;
    assert (nibble_out === exp_nib) else begin
      bad++;
      $error("FAIL %s nibble t=%0d got=%h exp=%h", tag, t, nibble_out, exp_nib);
    end
    total++;
    assert (digit_sel === exp_sel) else begin
      bad++;
      $error("FAIL %s digit_sel t=%0d got=%b exp=%b", tag, t, digit_sel, exp_sel);
    end
    total++;
    assert (frame_done === exp_fd) else begin
      bad++;
      $error("FAIL %s frame_done t=%0d got=%b exp=%b", tag, t, frame_done, exp_fd);
    end
  endtask

  // One clock: present inputs, take the edge, advance the model, check outputs
  task automatic cyc(input string tag, input logic ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge clk);
    #1;
    t++;
    if (t % FPER == 0 && m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    if (ld) begin
      m_shadow = v;
      m_pend   = 1'b1;
    end
    load  = 1'b0;
    value = 16'h0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 16'h0);
  endtask

  task automatic run_to(input string tag, input int pos);
    while (t % FPER != pos) cyc(tag, 1'b0, 16'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    lz_en = 1'b0;
    model_reset();

    // Reset held across several edges
    repeat (3) @(posedge clk);
    #1;
    check("in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release");
    idle("first_frame", 30);

    // Load mid-frame, shown from the next frame
    run_to("to_load", 8);
    cyc("load_1a3f", 1'b1, 16'h1A3F);
    idle("show_1a3f", 2 * FPER);

    // Leading-zero suppression
    lz_en = 1'b1;
    #1;
    check("lz_on_now");
    run_to("lz_sync", 3);
    cyc("load_0050", 1'b1, 16'h0050);
    idle("lz_0050", 2 * FPER);
    cyc("load_0000", 1'b1, 16'h0000);
    idle("lz_0000", 2 * FPER);
    lz_en = 1'b0;
    idle("nolz_0000", FPER);
    cyc("load_0050b", 1'b1, 16'h0050);
    idle("nolz_0050", 2 * FPER);

    // Two loads in one frame, last one wins
    run_to("to_dbl", 3);
    cyc("load_1111", 1'b1, 16'h1111);
    run_to("to_dbl2", 10);
    cyc("load_2222", 1'b1, 16'h2222);
    idle("show_2222", 2 * FPER);

    // Load on the wrap edge waits one extra frame
    run_to("to_wrap", FPER - 1);
    cyc("load_wrap", 1'b1, 16'hBEEF);
    idle("wrap_defer", 2 * FPER + 3);

    // Random loads and lz_en changes
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rv;
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      cyc("random", ($urandom_range(0, 7) == 0), rv);
    end

    // Reset during GAP of digit 2 with a load pending
    run_to("to_pend", 5);
    cyc("load_pend", 1'b1, 16'h7777);
    run_to("to_gap2", 2 * DPER + PRE);
    rst = 1'b1;
    #1;
    total++;
    assert (digit_sel === 4'b1110) else begin
      bad++;
      $error("FAIL rst_mid_sel got=%b exp=%b", digit_sel, 4'b1110);
    end
    total++;
    assert (nibble_out === 4'h0) else begin
      bad++;
      $error("FAIL rst_mid_nib got=%h exp=%h", nibble_out, 4'h0);
    end
    model_reset();
    check("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release");
    idle("after_rst", 3 * FPER);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Upstream driver for the hex-to-7-segment decoder in the FPGA display path.
- Holds a multi-digit hex value and time-multiplexes it onto one shared 4-bit digit bus.
- Drives active-low digit enables, with a blanking gap between digits to prevent ghosting.
- Adds tear-free value updates, applied only at frame boundaries, and optional leading-zero suppression.

Parameters:
- DIGITS, 4, number of multiplexed digits; index 0 is the least significant (rightmost) digit.
- PRESCALE, 50000, clock cycles each digit is lit per visit; must be >= 1.
- BLANK_CYCLES, 16, clock cycles with all digits off between visits; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value into the shadow register.
- value  in  4*DIGITS  hex value; nibble i = value[4i+3:4i] belongs to digit i.
- lz_en  in  1  1 = suppress leading zeros.
- nibble_out  out  4  nibble of the current digit; feeds the decoder's data_in.
- digit_sel  out  DIGITS  active-low digit enables; at most one bit is 0 at any time.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Registers:
  - state in {SHOW, GAP}
  - idx, range 0..DIGITS-1
  - cnt, sized for max(PRESCALE, BLANK_CYCLES)
  - active[4*DIGITS], shadow[4*DIGITS], pending
  - frame_done, registered
- Reset (async, rst=1): state=SHOW, idx=0, cnt=0, active=0, shadow=0, pending=0, frame_done=0.
  - Hence digit_sel = {1..1,0} and nibble_out = 0 while in reset and on the first cycle after release.
- nibble_out and digit_sel are combinational decodes of registered state, active and lz_en. There is no extra pipeline stage.
- nibble_out = active nibble idx in both SHOW and GAP.
- SHOW:
  - digit_sel bit idx = 0 unless the digit is suppressed (then all 1s); all other bits are 1.
  - cnt counts 0..PRESCALE-1. At PRESCALE-1: cnt=0, state=GAP.
- GAP:
  - digit_sel = all 1s.
  - cnt counts 0..BLANK_CYCLES-1. At BLANK_CYCLES-1: cnt=0, state=SHOW, idx advances.
  - If idx was not DIGITS-1: idx+1.
  - If idx was DIGITS-1: idx=0 and frame_done=1 for the next cycle. If pending, then active<=shadow and pending<=0 in the same edge.
- Digit period = PRESCALE+BLANK_CYCLES cycles; frame period = DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- load=1:
  - shadow<=value and pending<=1 on that edge.
  - active never changes mid-frame.
  - Multiple loads in one frame: the last one wins.
  - load on the wrap edge itself: the wrap copies the old shadow, and the new value waits one more frame (pending stays 1).
- Leading-zero suppression: digit i (i>0) is suppressed iff lz_en=1 and active nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never suppressed.
  - lz_en is not registered; a change takes effect on the same cycle.
- A suppressed digit still consumes its full SHOW/GAP time slot, so the frame timing is unchanged.
- Reset mid-operation (any state, any cnt) returns to the reset values immediately. A pending load is discarded.

Decomposition:
- Shared display include file holds the SHOW/GAP state encodings and the default PRESCALE/BLANK_CYCLES constants, so the decoder top level and the scanner agree.
- One natural combinational sub-module: lz_mask. Input is active and lz_en; output is a DIGITS-bit suppress vector, with bit 0 tied to 0.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 (digit period 6 cycles, frame 24).
- Reset release:
  - digit_sel=1110, nibble_out=0 for 4 cycles, then 1111 for 2 cycles, then 1101 for 4 cycles.
  - frame_done first pulses 24 cycles after release.
- Load 16'h1A3F at cycle 8:
  - Rest of the frame shows nibble 0.
  - After the frame_done pulse, digits 0..3 show nibble_out F, 3, A, 1, with digit_sel 1110, 1101, 1011, 0111 respectively.
- Leading zeros, lz_en=1:
  - value 16'h0050 → digits 3 and 2 show digit_sel 1111 during SHOW; digit 1 shows 5; digit 0 shows 0.
  - value 16'h0000 → only digit 0 lit.
  - Same values with lz_en=0 → all four digits lit.
- Loads 16'h1111 then 16'h2222 in the same frame → next frame shows only 2s; 1s never appear.
  - A load asserted exactly on the wrap edge appears one frame later.
- rst pulsed during GAP of digit 2 with a load pending:
  - Immediately digit_sel=1110, nibble_out=0.
  - After release, the pending value never appears.
